// File: rtl/pb_ctrl_defs.sv
// Shared definitions for the push-button controller bank.
// Holds the per-channel FSM encoding, default parameter values and the
// per-channel output payload type used between pb_channel and pb_ctrl_bank.
package pb_ctrl_defs;

   localparam int unsigned DEF_N_CH       = 2;
   localparam int unsigned DEF_SAMPLE_DIV = 1000000;
   localparam int unsigned DEF_DEB_LEN    = 4;
   localparam int unsigned DEF_LONG_CNT   = 200;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } pb_state_e;

   // Registered outputs of one channel
   typedef struct packed {
      logic deb;
      logic short_p;
      logic long_p;
      logic cen;
   } pb_ch_out_t;

endpackage

// File: rtl/pb_channel.sv
// One push-button channel: 2-flop synchroniser, tick-sampled debounce
// history, IDLE/PRESSED/LONG press FSM with saturating hold counter, and
// the run/pause flag toggled by short presses.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   tick_i  one-clk sample strobe from the shared divider
//   pb_i    raw asynchronous button input, active high
//   ch_o    registered channel outputs (debounced level, pulses, enable)
module pb_channel
   import pb_ctrl_defs::*;
#(
   parameter int unsigned DEB_LEN  = DEF_DEB_LEN,
   parameter int unsigned LONG_CNT = DEF_LONG_CNT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       pb_i,
   output pb_ch_out_t ch_o
);

   localparam int unsigned CNT_W = $clog2(LONG_CNT + 1);

   logic [1:0]         sync_q;
   logic [DEB_LEN-1:0] hist_q, hist_d;
   logic               deb_q, deb_d;
   pb_state_e          state_q, state_d;
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic               short_q, short_d;
   logic               long_q, long_d;
   logic               cen_q, cen_d;
   logic               hold_last_c;

   // Last tick before the hold qualifies as long
   assign hold_last_c = tick_i && (hold_q == CNT_W'(LONG_CNT - 1));

   // Synchroniser, debounce and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         hist_q  <= '0;
         deb_q   <= 1'b0;
         hold_q  <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         cen_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], pb_i};
         hist_q  <= hist_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         short_q <= short_d;
         long_q  <= long_d;
         cen_q   <= cen_d;
      end
   end

   // Debounce: level changes only when the whole history agrees
   always_comb begin
      hist_d = hist_q;
      deb_d  = deb_q;
      if (tick_i) begin
         hist_d = {hist_q[DEB_LEN-2:0], sync_q[1]};
         if (&hist_d) begin
            deb_d = 1'b1;
         end else if (~|hist_d) begin
            deb_d = 1'b0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a debounced edge wins over a coincident tick
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (deb_q) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            if (!deb_q) begin
               state_d = ST_IDLE;
            end else if (hold_last_c) begin
               state_d = ST_LONG;
            end
         end
         ST_LONG: begin
            if (!deb_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: hold counter, pulses and run/pause flag
   always_comb begin
      hold_d  = hold_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      cen_d   = cen_q;
      unique case (state_q)
         ST_IDLE: begin
            if (deb_q) hold_d = '0;
         end
         ST_PRESSED: begin
            if (!deb_q) begin
               short_d = 1'b1;
               cen_d   = ~cen_q;
            end else if (tick_i && (hold_q < CNT_W'(LONG_CNT))) begin
               hold_d = hold_q + CNT_W'(1);
               if (hold_last_c) begin
                  long_d = 1'b1;
                  cen_d  = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   assign ch_o.deb     = deb_q;
   assign ch_o.short_p = short_q;
   assign ch_o.long_p  = long_q;
   assign ch_o.cen     = cen_q;

endmodule

// File: rtl/pb_ctrl_bank.sv
// Bank of N_CH independent push-button controllers sharing one sample
// tick divider.
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   pb_in         raw button inputs, active high, asynchronous
//   pb_deb        debounced level per channel
//   short_pulse   one-clk pulse per short press, at release
//   long_pulse    one-clk pulse when a hold reaches LONG_CNT ticks
//   count_enable  per-channel run/pause flag
module pb_ctrl_bank
   import pb_ctrl_defs::*;
#(
   parameter int unsigned N_CH       = DEF_N_CH,
   parameter int unsigned SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int unsigned DEB_LEN    = DEF_DEB_LEN,
   parameter int unsigned LONG_CNT   = DEF_LONG_CNT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] pb_deb,
   output logic [N_CH-1:0] short_pulse,
   output logic [N_CH-1:0] long_pulse,
   output logic [N_CH-1:0] count_enable
);

   localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             div_wrap_c;

   assign div_wrap_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // Shared sample divider; tick is registered and lasts one clk
   always_comb begin
      div_d  = div_wrap_c ? '0 : div_q + DIV_W'(1);
      tick_d = div_wrap_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   pb_ch_out_t ch_out [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pb_channel #(
         .DEB_LEN  (DEB_LEN),
         .LONG_CNT (LONG_CNT)
      ) u_ch (
         .clk_i  (clk),
         .rst_ni (reset),
         .tick_i (tick_q),
         .pb_i   (pb_in[g]),
         .ch_o   (ch_out[g])
      );

      assign pb_deb[g]       = ch_out[g].deb;
      assign short_pulse[g]  = ch_out[g].short_p;
      assign long_pulse[g]   = ch_out[g].long_p;
      assign count_enable[g] = ch_out[g].cen;
   end

endmodule

// File: tb/tb_pb_ctrl_bank.sv
// Directed bench for pb_ctrl_bank with SAMPLE_DIV=4, DEB_LEN=3, LONG_CNT=5.
// Short presses are held 16 clk so the debounced hold stays below LONG_CNT
// ticks; long presses are held 60 clk.
module tb_pb_ctrl_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] pb_in = 2'b00;
   logic [1:0] pb_deb, short_pulse, long_pulse, count_enable;

   int n_checks = 0;
   int n_errors = 0;

   pb_ctrl_bank #(
      .N_CH       (2),
      .SAMPLE_DIV (4),
      .DEB_LEN    (3),
      .LONG_CNT   (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pb_in        (pb_in),
      .pb_deb       (pb_deb),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .count_enable (count_enable)
   );

   always #5 clk = ~clk;

   // Event monitor sampled on the falling edge
   int         cyc = 0;
   int         n_short [2] = '{0, 0};
   int         n_long  [2] = '{0, 0};
   int         n_rise  [2] = '{0, 0};
   int         t_rise  [2] = '{0, 0};
   int         t_long  [2] = '{0, 0};
   int         n_both  = 0;
   int         n_viol  = 0;
   logic [1:0] deb_prev = 2'b00;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      deb_prev <= pb_deb;
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            if (short_pulse[c]) n_short[c] <= n_short[c] + 1;
            if (long_pulse[c]) begin
               n_long[c] <= n_long[c] + 1;
               t_long[c] <= cyc + 1;
            end
            if (pb_deb[c] && !deb_prev[c]) begin
               n_rise[c] <= n_rise[c] + 1;
               t_rise[c] <= cyc + 1;
            end
         end
         if (short_pulse == 2'b11) n_both <= n_both + 1;
         if ((short_pulse & long_pulse) != 2'b00) n_viol <= n_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press mask for hold clk, release, then let the release settle
   task automatic press(input logic [1:0] mask, input int hold);
      pb_in = mask;
      idle(hold);
      pb_in = 2'b00;
      idle(30);
   endtask

   int s_short0, s_short1, s_long0, s_long1, s_rise0, s_both, t_press;
   bit seen;

   initial begin
      // Reset state
      idle(3);
      check("rst_deb", 32'(pb_deb), 0);
      check("rst_short", 32'(short_pulse), 0);
      check("rst_long", 32'(long_pulse), 0);
      check("rst_cen", 32'(count_enable), 0);
      reset = 1'b1;
      idle(5);

      // Short press on channel 0, debounce latency and toggle
      s_short0 = n_short[0]; s_long0 = n_long[0]; s_rise0 = n_rise[0];
      t_press = cyc;
      press(2'b01, 16);
      check("deb_rise_cnt", 32'(n_rise[0] - s_rise0), 1);
      check("deb_lat_ok", 32'((t_rise[0] - t_press >= 11) && (t_rise[0] - t_press <= 14)), 1);
      check("short0_cnt", 32'(n_short[0] - s_short0), 1);
      check("long0_none", 32'(n_long[0] - s_long0), 0);
      check("cen_after_short", 32'(count_enable), 32'h1);
      check("deb_released", 32'(pb_deb), 0);

      // Bouncing input never debounces high
      s_short0 = n_short[0]; s_long0 = n_long[0]; s_rise0 = n_rise[0];
      for (int i = 0; i < 10; i++) begin
         pb_in[0] = ~pb_in[0];
         idle(3);
      end
      pb_in = 2'b00;
      idle(30);
      check("bounce_rise", 32'(n_rise[0] - s_rise0), 0);
      check("bounce_short", 32'(n_short[0] - s_short0), 0);
      check("bounce_long", 32'(n_long[0] - s_long0), 0);
      check("bounce_cen", 32'(count_enable), 32'h1);

      // Long press on channel 1 after enabling it
      press(2'b10, 16);
      check("cen1_set", 32'(count_enable), 32'h3);
      s_short1 = n_short[1]; s_long1 = n_long[1];
      press(2'b10, 60);
      check("long1_cnt", 32'(n_long[1] - s_long1), 1);
      check("long1_delay", 32'(t_long[1] - t_rise[1]), 20);
      check("long1_no_short", 32'(n_short[1] - s_short1), 0);
      check("cen1_cleared", 32'(count_enable), 32'h1);

      // Simultaneous short presses on both channels
      s_short0 = n_short[0]; s_short1 = n_short[1]; s_both = n_both;
      press(2'b11, 16);
      check("both_same_clk", 32'(n_both - s_both), 1);
      check("both_short0", 32'(n_short[0] - s_short0), 1);
      check("both_short1", 32'(n_short[1] - s_short1), 1);
      check("both_cen", 32'(count_enable), 32'h2);

      // Reset in the middle of a PRESSED hold discards the press
      pb_in = 2'b01;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = pb_deb[0];
      end
      check("rst_mid_deb_rose", 32'(seen), 1);
      idle(13);
      reset = 1'b0;
      #1;
      check("rst_async_outs", 32'({pb_deb, short_pulse, long_pulse, count_enable}), 0);
      pb_in = 2'b00;
      idle(3);
      reset = 1'b1;
      s_short0 = n_short[0]; s_long0 = n_long[0]; s_rise0 = n_rise[0];
      idle(30);
      check("rst_no_short", 32'(n_short[0] - s_short0), 0);
      check("rst_no_long", 32'(n_long[0] - s_long0), 0);
      check("rst_no_rise", 32'(n_rise[0] - s_rise0), 0);
      check("rst_cen_zero", 32'(count_enable), 0);

      // Two back-to-back short presses on channel 0
      s_short0 = n_short[0];
      press(2'b01, 16);
      check("b2b_cen_first", 32'(count_enable[0]), 1);
      press(2'b01, 16);
      check("b2b_cen_second", 32'(count_enable[0]), 0);
      check("b2b_short_cnt", 32'(n_short[0] - s_short0), 2);

      check("no_short_long_overlap", 32'(n_viol), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
